wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback datapath.
- Captures MEM-stage control and results each cycle.
- Takes the synchronous data-memory read word, which returns one cycle after the address is presented. Aligns, sign- or zero-extends it per load type and selects the final register-file write value.
- Holds the returned load word across stalls so a stalled load never loses its data.

---
 rtl/wb_stage.sv | 203 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: MEM/WB pipeline register and writeback datapath.
//
// Registers the MEM-stage control and results each cycle. The synchronous data
// memory returns its read word in the cycle after the address is captured, so
// the load is aligned and extended combinationally from that live word. While
// the stage is stalled, the first returned word is kept in a hold register so
// that a stalled load keeps its data after the memory moves on.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-low reset
//   stall          hold stage contents this cycle
//   flush          replace captured instruction with a bubble (beats stall)
//   in_valid       MEM-stage instruction valid
//   in_rd          destination register
//   in_reg_we      instruction writes rd
//   in_wb_sel      00 ALU, 01 load, 10 PC+4, 11 zero
//   in_funct3      load type (LB/LH/LW/LBU/LHU)
//   in_alu_result  ALU result / effective address
//   in_pc_plus4    link value
//   mem_rdata      data memory read word, valid the cycle after capture
//   wb_valid       stage holds a valid instruction
//   wb_rd          register-file write index
//   wb_we          register-file write enable
//   wb_data        register-file write data
//   load_misaligned valid load with misaligned address
//   load_illegal   valid load with unsupported funct3
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_we,
    output logic [XLEN-1:0]       wb_data,
    output logic                  load_misaligned,
    output logic                  load_illegal
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_ZERO = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stage registers
    logic                  valid_q,  valid_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    logic                  reg_we_q, reg_we_d;
    wb_sel_e               wb_sel_q, wb_sel_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [XLEN-1:0]       alu_q,    alu_d;
    logic [XLEN-1:0]       pc4_q,    pc4_d;
    logic [XLEN-1:0]       hold_q,   hold_d;
    logic                  held_q,   held_d;

    // Next-state: flush, then stall, then capture (reset handled in the flop).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/case tree can leave it unassigned and infer a latch.
        valid_d  = valid_q;
        rd_d     = rd_q;
        reg_we_d = reg_we_q;
        wb_sel_d = wb_sel_q;
        funct3_d = funct3_q;
        alu_d    = alu_q;
        pc4_d    = pc4_q;
        hold_d   = hold_q;
        held_d   = held_q;

        if (flush) begin
            // Remaining fields are irrelevant once valid is cleared.
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
            held_d   = 1'b0;
        end else if (stall) begin
            // Only the first stalled cycle sees this instruction's read word;
            // later cycles may already see the memory's next response.
            if (!held_q) begin
                hold_d = mem_rdata;
                held_d = 1'b1;
            end
        end else begin
            valid_d  = in_valid;
            rd_d     = in_rd;
            reg_we_d = in_reg_we;
            wb_sel_d = wb_sel_e'(in_wb_sel);
            funct3_d = in_funct3;
            alu_d    = in_alu_result;
            pc4_d    = in_pc_plus4;
            held_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order. The hold register is a plain flop, not
        // a memory, so it is cleared along with the rest of the stage.
        if (!reset) begin
            valid_q  <= 1'b0;
            rd_q     <= '0;
            reg_we_q <= 1'b0;
            wb_sel_q <= SEL_ALU;
            funct3_q <= '0;
            alu_q    <= '0;
            pc4_q    <= '0;
            hold_q   <= '0;
            held_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            reg_we_q <= reg_we_d;
            wb_sel_q <= wb_sel_d;
            funct3_q <= funct3_d;
            alu_q    <= alu_d;
            pc4_q    <= pc4_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
        end
    end

    // Load alignment / extension
    logic [XLEN-1:0] load_word;
    logic [1:0]      off;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            is_load;
    logic            misaligned;
    logic            illegal;
    logic [XLEN-1:0] load_val;

    assign load_word = held_q ? hold_q : mem_rdata;
    assign off       = alu_q[1:0];
    assign byte_v    = load_word[8*off +: 8];
    assign half_v    = off[1] ? load_word[31:16] : load_word[15:0];
    assign is_load   = valid_q && (wb_sel_q == SEL_LOAD);

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        load_val   = '0;
        case (funct3_q)
            F3_LB:  load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: load_val = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                load_val   = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = is_load && off[0];
            end
            F3_LHU: begin
                load_val   = {{(XLEN-16){1'b0}}, half_v};
                misaligned = is_load && off[0];
            end
            F3_LW: begin
                load_val   = load_word;
                misaligned = is_load && (off != 2'b00);
            end
            default: illegal = is_load;
        endcase
        if (misaligned) begin
            load_val = '0;
        end
    end

    // Writeback select
    always_comb begin
        wb_data = '0;
        case (wb_sel_q)
            SEL_ALU:  wb_data = alu_q;
            SEL_LOAD: wb_data = load_val;
            SEL_PC4:  wb_data = pc4_q;
            SEL_ZERO: wb_data = '0;
            default:  wb_data = '0;
        endcase
    end

    assign wb_valid        = valid_q;
    assign wb_rd           = rd_q;
    assign load_misaligned = misaligned;
    assign load_illegal    = illegal;
    assign wb_we           = valid_q && reg_we_q && (rd_q != '0) && !misaligned && !illegal;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage: self-checking bench for wb_stage. Directed scenarios use values
// worked out by hand; the random scenario compares against a behavioural model
// that tracks the instruction in the stage and the word it will write back.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_reg_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_pc_plus4, mem_rdata;
    logic        wb_valid, wb_we, load_misaligned, load_illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rd(in_rd), .in_reg_we(in_reg_we),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .load_misaligned(load_misaligned), .load_illegal(load_illegal)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
    } instr_t;

    instr_t      m_cur;
    logic        m_held;
    logic [31:0] m_hold;
    logic        m_dc;   // fields other than valid/we are unknown after a flush

    function automatic logic [31:0] model_load(logic [2:0] f3, int unsigned off, logic [31:0] w);
        int unsigned b, h;
        b = (w / (32'd1 << (8 * off))) % 256;
        h = (off >= 2) ? (w / 65536) : (w % 65536);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'h10000 : 32'(h);
            3'd2:    return w;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    // {valid, rd, we, data, misaligned, illegal}
    function automatic logic [40:0] model_out();
        int unsigned off;
        logic        ld, mis, ill, we;
        logic [31:0] word, data;
        off  = int'(m_cur.alu % 4);
        word = m_held ? m_hold : mem_rdata;
        ld   = m_cur.valid && (m_cur.sel == 2'd1);
        mis  = ld && (((m_cur.f3 == 3'd1 || m_cur.f3 == 3'd5) && (off % 2 == 1)) ||
                      (m_cur.f3 == 3'd2 && off != 0));
        ill  = ld && (m_cur.f3 == 3'd3 || m_cur.f3 == 3'd6 || m_cur.f3 == 3'd7);
        we   = m_cur.valid && m_cur.we && (m_cur.rd != 0) && !mis && !ill;
        case (m_cur.sel)
            2'd0:    data = m_cur.alu;
            2'd1:    data = mis ? 32'd0 : model_load(m_cur.f3, off, word);
            2'd2:    data = m_cur.pc;
            default: data = 32'd0;
        endcase
        return {m_cur.valid, m_cur.rd, we, data, mis, ill};
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_cur  = '0;
            m_held = 1'b0;
            m_hold = '0;
            m_dc   = 1'b0;
        end else if (flush) begin
            m_cur.valid = 1'b0;
            m_cur.we    = 1'b0;
            m_held      = 1'b0;
            m_dc        = 1'b1;
        end else if (stall) begin
            if (!m_held) begin
                m_hold = mem_rdata;
                m_held = 1'b1;
            end
        end else begin
            m_cur = '{in_valid, in_rd, in_reg_we, in_wb_sel, in_funct3, in_alu_result, in_pc_plus4};
            m_held = 1'b0;
            m_dc   = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic [4:0] rd, logic we, logic [1:0] sel,
                         logic [2:0] f3, logic [31:0] alu, logic [31:0] pc);
        in_valid = v; in_rd = rd; in_reg_we = we; in_wb_sel = sel;
        in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc;
    endtask

    task automatic rand_inputs();
        drive(1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
              3'($urandom), $urandom, $urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            stall = 1'($urandom); flush = 1'($urandom); mem_rdata = $urandom;
            cycle();
            #1;
            n_tests++;
            if ({wb_valid, wb_we, wb_data, load_misaligned, load_illegal} !== 36'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got valid=%b we=%b data=%h mis=%b ill=%b, want all 0",
                         i, wb_valid, wb_we, wb_data, load_misaligned, load_illegal);
            end
        end
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, 5'd5, 1'b1, 2'b00, 3'd0, 32'h1234_5678, 32'h0);
        cycle();
        #1;
        n_tests++;
        if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL alu_wb: got we=%b rd=%0d data=%h, want we=1 rd=5 data=12345678",
                     wb_we, wb_rd, wb_data);
        end
        drive(1'b1, 5'd0, 1'b1, 2'b00, 3'd0, 32'h1234_5678, 32'h0);
        cycle();
        #1;
        n_tests++;
        if (wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_rd0: got we=%b, want 0", wb_we);
        end
    endtask

    task automatic test_load_extract();
        logic [1:0]  offs [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010};
        logic [31:0] exps [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_80FF,
                                  32'hFFFF_80FF, 32'h80FF_7F01};
        mem_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd3, 1'b1, 2'b01, f3s[i], {30'h400, offs[i]}, 32'h0);
            cycle();
            #1;
            n_tests++;
            if (wb_data !== exps[i] || wb_we !== 1'b1) begin
                n_fail++;
                $display("FAIL load_extract[%0d]: got data=%h we=%b, want data=%h we=1",
                         i, wb_data, wb_we, exps[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        drive(1'b1, 5'd7, 1'b1, 2'b01, 3'b010, 32'h0000_0100, 32'h0);
        mem_rdata = 32'hAAAA_AAAA;
        cycle();                       // LW captured; its data is live now
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) mem_rdata = 32'h5555_5555;
            if (i == 3) stall = 1'b0;  // last check: stall just dropped
            #1;
            n_tests++;
            if (wb_data !== 32'hAAAA_AAAA || wb_we !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got data=%h we=%b, want data=aaaaaaaa we=1",
                         i, wb_data, wb_we);
            end
            if (i < 3) cycle();
        end
        drive(1'b1, 5'd8, 1'b1, 2'b01, 3'b010, 32'h0000_0200, 32'h0);
        cycle();
        #1;
        n_tests++;
        if (wb_data !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL stall_release: got data=%h, want 55555555", wb_data);
        end
    endtask

    task automatic test_bad_loads();
        mem_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 5'd9, 1'b1, 2'b01, 3'b010, 32'h0000_0102, 32'h0);
        cycle();
        #1;
        n_tests++;
        if ({load_misaligned, load_illegal, wb_we, wb_data} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL misaligned_lw: got mis=%b ill=%b we=%b data=%h, want 1 0 0 0",
                     load_misaligned, load_illegal, wb_we, wb_data);
        end
        drive(1'b1, 5'd9, 1'b1, 2'b01, 3'b011, 32'h0000_0100, 32'h0);
        cycle();
        #1;
        n_tests++;
        if ({load_misaligned, load_illegal, wb_we} !== 3'b010) begin
            n_fail++;
            $display("FAIL illegal_f3: got mis=%b ill=%b we=%b, want 0 1 0",
                     load_misaligned, load_illegal, wb_we);
        end
    endtask

    task automatic test_flush_priority();
        drive(1'b1, 5'd4, 1'b1, 2'b01, 3'b010, 32'h0000_0300, 32'h0);
        mem_rdata = 32'h1111_2222;
        cycle();
        stall = 1'b1;
        cycle();                       // load word now held
        flush = 1'b1;
        cycle();
        stall = 1'b0; flush = 1'b0;
        #1;
        n_tests++;
        if ({wb_valid, wb_we, load_misaligned, load_illegal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_over_stall: got valid=%b we=%b mis=%b ill=%b, want 0 0 0 0",
                     wb_valid, wb_we, load_misaligned, load_illegal);
        end
        drive(1'b1, 5'd1, 1'b1, 2'b10, 3'd0, 32'hFFFF_0000, 32'h0000_0104);
        cycle();
        #1;
        n_tests++;
        if ({wb_we, wb_data} !== {1'b1, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL pc_plus4: got we=%b data=%h, want we=1 data=00000104", wb_we, wb_data);
        end
    endtask

    task automatic test_random();
        logic [40:0] exp_v, got_v;
        for (int i = 0; i < 400; i++) begin
            mem_rdata = $urandom;
            #1;
            exp_v = model_out();
            got_v = {wb_valid, wb_rd, wb_we, wb_data, load_misaligned, load_illegal};
            n_tests++;
            if (m_dc ? ({got_v[40], got_v[34], got_v[1:0]} !== {exp_v[40], exp_v[34], exp_v[1:0]})
                     : (got_v !== exp_v)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h, want %h (dc=%b)", i, got_v, exp_v, m_dc);
            end
            rand_inputs();
            in_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 1) * 4) + $urandom_range(0, 2) * ($urandom_range(0, 1) ? 1 : 0));
            reset = ($urandom_range(0, 49) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 9) < 3);
            cycle();
        end
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; mem_rdata = '0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 32'd0, 32'd0);
        m_cur = '0; m_held = 1'b0; m_hold = '0; m_dc = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_extract();
        test_stall_hold();
        test_bad_loads();
        test_flush_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
